// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dp_ram_sync dual-port RAM.
// The parity helper is used only when DP_RAM_PARITY_EN is defined.
package dp_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int RD_FIRST = 0;
   localparam int WR_FIRST = 1;

   // Narrower words are zero-extended by the caller, which leaves even parity unchanged.
   function automatic logic even_parity(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/dp_ram_port_pipe.sv
// Per-port read pipeline: 1- or 2-cycle latency, one-cycle valid pulse, held data.
// Flags are pulse-type (zero whenever valid is low). Optional feature macro: DP_RAM_PARITY_EN (handled by the top).
module dp_ram_port_pipe #(
   parameter int DATA_W  = 8,
   parameter int FLAG_W  = 1,
   parameter int OUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [DATA_W-1:0] din,
   input  logic [FLAG_W-1:0] fin,
   output logic              valid,
   output logic [DATA_W-1:0] dout,
   output logic [FLAG_W-1:0] fout
);

   logic              v1;
   logic [DATA_W-1:0] d1;
   logic [FLAG_W-1:0] f1;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         d1 <= '0;
         f1 <= '0;
      end else begin
         v1 <= req;
         f1 <= req ? fin : '0;
         if (req) d1 <= din;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic              v2;
         logic [DATA_W-1:0] d2;
         logic [FLAG_W-1:0] f2;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v2 <= 1'b0;
               d2 <= '0;
               f2 <= '0;
            end else begin
               v2 <= v1;
               f2 <= f1;
               if (v1) d2 <= d1;
            end
         end

         assign valid = v2;
         assign dout  = d2;
         assign fout  = f2;
      end else begin : g_direct
         assign valid = v1;
         assign dout  = d1;
         assign fout  = f1;
      end
   endgenerate

endmodule

// File: rtl/dp_ram_sync.sv
// Single-clock true dual-port RAM with clear engine, collision flag and selectable read-during-write.
// Optional macro DP_RAM_PARITY_EN adds a stored even-parity bit, a_perr/b_perr outputs and inj_perr.
module dp_ram_sync
   import dp_ram_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 7,
   parameter int                RD_MODE  = RD_FIRST,
   parameter int                OUT_REG  = 0,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef DP_RAM_PARITY_EN
   input  logic              inj_perr,
   output logic              a_perr,
   output logic              b_perr,
`endif
   input  logic              clr_req,
   output logic              ready,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_din,
   output logic [DATA_W-1:0] a_dout,
   output logic              a_valid,
   input  logic              b_en,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_din,
   output logic [DATA_W-1:0] b_dout,
   output logic              b_valid,
   output logic              collision
);

   localparam int DEPTH = 2 ** ADDR_W;
`ifdef DP_RAM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
   localparam int FLAG_W = 2;
`else
   localparam int WORD_W = DATA_W;
   localparam int FLAG_W = 1;
`endif

   state_t            state, state_nx;
   logic [ADDR_W-1:0] ptr, ptr_nx;
   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] a_wword, b_wword, init_word, a_rword, b_rword;
   logic              a_acc, b_acc, a_wr, b_wr, same_addr, coll_now;
   logic [FLAG_W-1:0] a_fin, b_fin, a_fout, b_fout;

   assign ready     = (state == READY);
   assign same_addr = (a_addr == b_addr);
   assign a_acc     = rst_n & ready & a_en;
   assign b_acc     = rst_n & ready & b_en;
   assign a_wr      = a_acc & a_we;
   // Port A owns the word when both ports write the same address.
   assign b_wr      = b_acc & b_we & ~(a_wr & same_addr);
   assign coll_now  = a_acc & b_acc & same_addr & (a_we | b_we);

`ifdef DP_RAM_PARITY_EN
   assign a_wword   = {even_parity(64'(a_din)) ^ inj_perr, a_din};
   assign b_wword   = {even_parity(64'(b_din)), b_din};
   assign init_word = {even_parity(64'(INIT_VAL)), INIT_VAL};
   assign a_fin     = {even_parity(64'(a_rword[DATA_W-1:0])) ^ a_rword[DATA_W], coll_now};
   assign b_fin     = {even_parity(64'(b_rword[DATA_W-1:0])) ^ b_rword[DATA_W], coll_now};
   assign a_perr    = a_fout[1];
   assign b_perr    = b_fout[1];
`else
   assign a_wword   = a_din;
   assign b_wword   = b_din;
   assign init_word = INIT_VAL;
   assign a_fin     = coll_now;
   assign b_fin     = coll_now;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      case (state)
         CLEAR: begin
            ptr_nx = ptr + 1'b1;
            if (&ptr) state_nx = READY;
         end
         READY: begin
            if (clr_req) begin
               state_nx = CLEAR;
               ptr_nx   = '0;
            end
         end
         default: state_nx = CLEAR;
      endcase
   end

   // NOTE: the array has no reset; the clear engine initialises it, keeping it mappable to block RAM.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[ptr] <= init_word;
      end else begin
         if (a_wr) mem[a_addr] <= a_wword;
         if (b_wr) mem[b_addr] <= b_wword;
      end
   end

   // Write-first forwards whatever word this cycle leaves at the address, from either port.
   always_comb begin
      a_rword = mem[a_addr];
      b_rword = mem[b_addr];
      if (RD_MODE == WR_FIRST) begin
         if (a_wr)                   a_rword = a_wword;
         else if (b_wr && same_addr) a_rword = b_wword;
         if (b_wr)                   b_rword = b_wword;
         else if (a_wr && same_addr) b_rword = a_wword;
      end
   end

   dp_ram_port_pipe #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .OUT_REG(OUT_REG)) u_pipe_a (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (a_acc),
      .din   (a_rword[DATA_W-1:0]),
      .fin   (a_fin),
      .valid (a_valid),
      .dout  (a_dout),
      .fout  (a_fout)
   );

   dp_ram_port_pipe #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .OUT_REG(OUT_REG)) u_pipe_b (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (b_acc),
      .din   (b_rword[DATA_W-1:0]),
      .fin   (b_fin),
      .valid (b_valid),
      .dout  (b_dout),
      .fout  (b_fout)
   );

   assign collision = a_fout[0] & b_fout[0];

endmodule
